wash_sequencer: RTL and testbench

Parametrised wash-cycle sequencer, the successor to the fixed one-step-per-clock washing machine FSM. Every phase has its own tick duration and the rinse pass repeats a configurable number of times. The block accepts a start request and pauses on an open door, resuming where it stopped. It drives the water valves, the motor mode, and the status outputs consumed by the panel logic.

---
 rtl/wash_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// wash_sequencer: parametrised wash-cycle sequencer.
// Runs fill/agitate/spin for the wash pass, then RINSE_N rinse passes, each
// phase lasting its own tick count. An open door pauses the sequence in place.
// Optional feature: define WM_DOOR_ABORT_EN to make an open door during either
// spin phase abort the cycle back to Idle instead of pausing.
module wash_sequencer #(
    parameter int CNT_W         = 8,
    parameter int FILL_TICKS    = 16,
    parameter int AGITATE_TICKS = 32,
    parameter int SPIN_TICKS    = 24,
    parameter int RINSE_N       = 2,
    parameter int RINSE_W       = 2
) (
    input  logic               clkorig,
    input  logic               power,
    input  logic               door,
    input  logic               start,
    output logic [2:0]         state,
    output logic [1:0]         finalwater,
    output logic [1:0]         motor,
    output logic               busy,
    output logic               paused,
    output logic               done,
    output logic [RINSE_W-1:0] rinse_left
);

    typedef enum logic [2:0] {
        OFF           = 3'd0,
        IDLE          = 3'd1,
        WASH_FILL     = 3'd2,
        WASH_AGITATE  = 3'd3,
        WASH_SPIN     = 3'd4,
        RINSE_FILL    = 3'd5,
        RINSE_AGITATE = 3'd6,
        RINSE_SPIN    = 3'd7
    } phase_t;

    localparam logic [CNT_W-1:0]   FILL_LOAD    = CNT_W'(FILL_TICKS - 1);
    localparam logic [CNT_W-1:0]   AGITATE_LOAD = CNT_W'(AGITATE_TICKS - 1);
    localparam logic [CNT_W-1:0]   SPIN_LOAD    = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [RINSE_W-1:0] RINSE_LOAD   = RINSE_W'(RINSE_N);
    localparam logic [RINSE_W-1:0] RINSE_ONE    = RINSE_W'(1);

    phase_t               r_state;
    logic [CNT_W-1:0]     r_timer;
    logic [RINSE_W-1:0]   r_rinseLeft;
    logic [1:0]           r_water;
    logic [1:0]           r_motor;
    logic                 r_busy;
    logic                 r_paused;
    logic                 r_done;

    phase_t               w_nextState;
    logic [CNT_W-1:0]     w_nextTimer;
    logic [RINSE_W-1:0]   w_nextRinse;
    logic [1:0]           w_nextWater;
    logic [1:0]           w_nextMotor;
    logic                 w_nextBusy;
    logic                 w_nextPaused;
    logic                 w_nextDone;
    logic                 w_abort;

`ifdef WM_DOOR_ABORT_EN
    assign w_abort = door && ((r_state == WASH_SPIN) || (r_state == RINSE_SPIN));
`else
    assign w_abort = 1'b0;
`endif

    // State register: phase, timer, rinse count and all registered outputs.
    always_ff @(posedge clkorig or negedge power) begin
        if (!power) begin
            r_state     <= OFF;
            r_timer     <= '0;
            r_rinseLeft <= '0;
            r_water     <= '0;
            r_motor     <= '0;
            r_busy      <= 1'b0;
            r_paused    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_timer     <= w_nextTimer;
            r_rinseLeft <= w_nextRinse;
            r_water     <= w_nextWater;
            r_motor     <= w_nextMotor;
            r_busy      <= w_nextBusy;
            r_paused    <= w_nextPaused;
            r_done      <= w_nextDone;
        end
    end

    // Next-state logic; a cycle still marked paused is held too, so the timer
    // only counts cycles in which the machine was really running.
    always_comb begin
        w_nextState  = r_state;
        w_nextTimer  = r_timer;
        w_nextRinse  = r_rinseLeft;
        w_nextPaused = 1'b0;
        w_nextDone   = 1'b0;
        case (r_state)
            OFF: begin
                w_nextState = IDLE;
            end
            IDLE: begin
                if (start && !door) begin
                    w_nextState = WASH_FILL;
                    w_nextTimer = FILL_LOAD;
                    w_nextRinse = RINSE_LOAD;
                end
            end
            default: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                    w_nextTimer = '0;
                    w_nextRinse = '0;
                end else if (door || r_paused) begin
                    w_nextPaused = door;
                end else if (r_timer != '0) begin
                    w_nextTimer = r_timer - CNT_ONE;
                end else begin
                    case (r_state)
                        WASH_FILL: begin
                            w_nextState = WASH_AGITATE;
                            w_nextTimer = AGITATE_LOAD;
                        end
                        WASH_AGITATE: begin
                            w_nextState = WASH_SPIN;
                            w_nextTimer = SPIN_LOAD;
                        end
                        WASH_SPIN: begin
                            w_nextState = RINSE_FILL;
                            w_nextTimer = FILL_LOAD;
                        end
                        RINSE_FILL: begin
                            w_nextState = RINSE_AGITATE;
                            w_nextTimer = AGITATE_LOAD;
                        end
                        RINSE_AGITATE: begin
                            w_nextState = RINSE_SPIN;
                            w_nextTimer = SPIN_LOAD;
                        end
                        RINSE_SPIN: begin
                            if (r_rinseLeft > RINSE_ONE) begin
                                w_nextState = RINSE_FILL;
                                w_nextTimer = FILL_LOAD;
                                w_nextRinse = r_rinseLeft - RINSE_ONE;
                            end else begin
                                w_nextState = IDLE;
                                w_nextTimer = '0;
                                w_nextRinse = '0;
                                w_nextDone  = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // Output decode from the upcoming phase; valves and motor are off while paused.
    always_comb begin
        w_nextBusy  = 1'b0;
        w_nextWater = 2'b00;
        w_nextMotor = 2'b00;
        case (w_nextState)
            WASH_FILL: begin
                w_nextBusy  = 1'b1;
                w_nextWater = 2'b10;
            end
            WASH_AGITATE: begin
                w_nextBusy  = 1'b1;
                w_nextWater = 2'b10;
                w_nextMotor = 2'b01;
            end
            WASH_SPIN: begin
                w_nextBusy  = 1'b1;
                w_nextWater = 2'b10;
                w_nextMotor = 2'b10;
            end
            RINSE_FILL: begin
                w_nextBusy  = 1'b1;
                w_nextWater = 2'b01;
            end
            RINSE_AGITATE: begin
                w_nextBusy  = 1'b1;
                w_nextWater = 2'b01;
                w_nextMotor = 2'b01;
            end
            RINSE_SPIN: begin
                w_nextBusy  = 1'b1;
                w_nextWater = 2'b01;
                w_nextMotor = 2'b10;
            end
            default: begin
            end
        endcase
        if (w_nextPaused) begin
            w_nextWater = 2'b00;
            w_nextMotor = 2'b00;
        end
    end

    assign state      = r_state;
    assign finalwater = r_water;
    assign motor      = r_motor;
    assign busy       = r_busy;
    assign paused     = r_paused;
    assign done       = r_done;
    assign rinse_left = r_rinseLeft;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed self-checking bench for wash_sequencer.
// Main instance uses FILL=2, AGITATE=3, SPIN=2, RINSE_N=2; a second instance
// covers the single-rinse boundary (RINSE_N=1, RINSE_W=1).
module tb_wash_sequencer;

    logic       clkorig = 1'b0;
    logic       power;
    logic       door;
    logic       start;

    logic [2:0] state;
    logic [1:0] finalwater;
    logic [1:0] motor;
    logic       busy;
    logic       paused;
    logic       done;
    logic [1:0] rinse_left;

    logic [2:0] stateOne;
    logic [1:0] finalwaterOne;
    logic [1:0] motorOne;
    logic       busyOne;
    logic       pausedOne;
    logic       doneOne;
    logic [0:0] rinseOne;

    int checkCount = 0;
    int errorCount = 0;

    // Expected state after edge S+k, where S is the start-accepting edge.
    int seqRun [0:21] = '{2,2,3,3,3,4,4,5,5,6,6,6,7,7,5,5,6,6,6,7,7,1};
    int seqOne [0:14] = '{2,2,3,3,3,4,4,5,5,6,6,6,7,7,1};

    wash_sequencer #(
        .CNT_W(8), .FILL_TICKS(2), .AGITATE_TICKS(3), .SPIN_TICKS(2),
        .RINSE_N(2), .RINSE_W(2)
    ) dut (
        .clkorig(clkorig), .power(power), .door(door), .start(start),
        .state(state), .finalwater(finalwater), .motor(motor), .busy(busy),
        .paused(paused), .done(done), .rinse_left(rinse_left)
    );

    wash_sequencer #(
        .CNT_W(8), .FILL_TICKS(2), .AGITATE_TICKS(3), .SPIN_TICKS(2),
        .RINSE_N(1), .RINSE_W(1)
    ) dutOne (
        .clkorig(clkorig), .power(power), .door(door), .start(start),
        .state(stateOne), .finalwater(finalwaterOne), .motor(motorOne), .busy(busyOne),
        .paused(pausedOne), .done(doneOne), .rinse_left(rinseOne)
    );

    always #5 clkorig = ~clkorig;

    function automatic int expWater(input int s);
        if (s >= 2 && s <= 4) return 2;
        if (s >= 5 && s <= 7) return 1;
        return 0;
    endfunction

    function automatic int expMotor(input int s);
        if (s == 3 || s == 6) return 1;
        if (s == 4 || s == 7) return 2;
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic d, input logic s);
        power = p;
        door  = d;
        start = s;
    endtask

    task automatic tick();
        @(posedge clkorig);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " state"}, state, 0);
        checkOutput({tag, " water"}, finalwater, 0);
        checkOutput({tag, " motor"}, motor, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " paused"}, paused, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " rinse"}, rinse_left, 0);
    endtask

    // Pulse start for one edge from Idle; returns just after the accepting edge.
    task automatic startRun();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    // Full unpaused run on the main instance, checked every cycle.
    task automatic fullRun(input string tag);
        int s;
        int r;
        startRun();
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) tick();
            s = seqRun[k];
            r = (k <= 13) ? 2 : ((k <= 20) ? 1 : 0);
            checkOutput($sformatf("%s state k=%0d", tag, k), state, s);
            checkOutput($sformatf("%s water k=%0d", tag, k), finalwater, expWater(s));
            checkOutput($sformatf("%s motor k=%0d", tag, k), motor, expMotor(s));
            checkOutput($sformatf("%s busy k=%0d", tag, k), busy, (s >= 2) ? 1 : 0);
            checkOutput($sformatf("%s rinse k=%0d", tag, k), rinse_left, r);
            checkOutput($sformatf("%s done k=%0d", tag, k), done, (k == 21) ? 1 : 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and power-up
        applyStimulus(1'b1, 1'b0, 1'b0);
        #2;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkAllZero("reset");
        tick();
        checkOutput("reset held state", state, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("powerup state", state, 1);
        checkOutput("powerup busy", busy, 0);

        // Scenario 1: normal run
        $display("[TB] scenario 1 normal run");
        fullRun("s1");

        // Scenario 2: start ignored with the door open
        $display("[TB] scenario 2 door interlock");
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("s2 door state a", state, 1);
        checkOutput("s2 door busy a", busy, 0);
        tick();
        checkOutput("s2 door state b", state, 1);
        checkOutput("s2 door busy b", busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s2 closed state", state, 1);
        fullRun("s2");

        // Scenario 3: pause for five cycles during wash agitate
        $display("[TB] scenario 3 pause mid-agitate");
        startRun();
        tick();
        tick();
        checkOutput("s3 agitate entry", state, 3);
        checkOutput("s3 agitate motor", motor, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("s3 hold state i=%0d", i), state, 3);
            checkOutput($sformatf("s3 hold paused i=%0d", i), paused, 1);
            checkOutput($sformatf("s3 hold motor i=%0d", i), motor, 0);
            checkOutput($sformatf("s3 hold water i=%0d", i), finalwater, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 8; k <= 27; k++) begin
            tick();
            if (k == 8) checkOutput("s3 resume paused", paused, 0);
            if (k <= 10) checkOutput($sformatf("s3 resume state k=%0d", k), state, 3);
            if (k == 11) checkOutput("s3 spin entry", state, 4);
            if (k == 27) checkOutput("s3 final state", state, 1);
            checkOutput($sformatf("s3 done k=%0d", k), done, (k == 27) ? 1 : 0);
        end

        // Scenario 4: power loss during rinse agitate
        $display("[TB] scenario 4 reset mid-run");
        startRun();
        for (int k = 1; k <= 9; k++) tick();
        checkOutput("s4 rinse agitate", state, 6);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkAllZero("s4 async");
        tick();
        checkOutput("s4 off state", state, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s4 idle state", state, 1);

        // Scenario 5: door opens during rinse spin
        $display("[TB] scenario 5 door during spin");
        startRun();
        for (int k = 1; k <= 12; k++) tick();
        checkOutput("s5 spin state", state, 7);
        checkOutput("s5 spin rinse", rinse_left, 2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef WM_DOOR_ABORT_EN
        checkOutput("s5 abort state", state, 1);
        checkOutput("s5 abort rinse", rinse_left, 0);
        checkOutput("s5 abort busy", busy, 0);
        checkOutput("s5 abort paused", paused, 0);
        checkOutput("s5 abort done", done, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("s5 after state i=%0d", i), state, 1);
            checkOutput($sformatf("s5 after done i=%0d", i), done, 0);
        end
`else
        checkOutput("s5 hold state", state, 7);
        checkOutput("s5 hold paused", paused, 1);
        checkOutput("s5 hold motor", motor, 0);
        checkOutput("s5 hold water", finalwater, 0);
        for (int k = 14; k <= 23; k++) begin
            tick();
            checkOutput($sformatf("s5 done k=%0d", k), done, (k == 23) ? 1 : 0);
        end
        checkOutput("s5 final state", state, 1);
`endif

        // Scenario 6: start held throughout, plus the single-rinse instance
        $display("[TB] scenario 6 held start and single rinse");
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s6 idle main", state, 1);
        checkOutput("s6 idle one", stateOne, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k <= 22; k++) begin
            tick();
            checkOutput($sformatf("s6 main state k=%0d", k), state, (k <= 21) ? seqRun[k] : 2);
            checkOutput($sformatf("s6 main done k=%0d", k), done, (k == 21) ? 1 : 0);
            if (k <= 15) begin
                checkOutput($sformatf("s6 one state k=%0d", k), stateOne, (k <= 14) ? seqOne[k] : 2);
                checkOutput($sformatf("s6 one done k=%0d", k), doneOne, (k == 14) ? 1 : 0);
                checkOutput($sformatf("s6 one rinse k=%0d", k), rinseOne, (k == 14) ? 0 : 1);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
